dffram_arbiter2: RTL and testbench
==================================

// Module: dffram_arbiter2
// PURPOSE
//  Two-requester round-robin arbiter and sequencer for one single-port DFFRAM macro (512x32, byte WE).
//  Each requester issues read/write commands over req/gnt; the block muxes the winner onto the RAM port
//  and returns read data one cycle after grant. Sits between two bus masters (e.g. CPU + DMA) and the RAM.
// PARAMETERS
//  AW          9   RAM address width (depth = 2**AW words)
//  WSIZE       4   bytes per word; data width DW = 8*WSIZE, WE width = WSIZE
//  INIT_VALUE  0   word written to every location by the init sweep (DW bits)
// PORTS
//  CLK        in   1      clock; all state updates on rising edge
//  RST        in   1      synchronous reset, active-high
//  req0/req1  in   1      requester n has a valid command this cycle
//  we0/we1    in   WSIZE  byte write enables; all-zero = read
//  addr0/addr1 in  AW     word address
//  wdata0/wdata1 in DW    write data
//  gnt0/gnt1  out  1      command accepted this cycle (combinational)
//  rvalid0/rvalid1 out 1  read data valid for requester n
//  rdata0/rdata1 out DW   read data; meaningful only while rvalidn=1
//  busy       out  1      init sweep in progress
//  ram_EN0    out  1      to RAM EN0
//  ram_WE0    out  WSIZE  to RAM WE0
//  ram_A0     out  AW     to RAM A0
//  ram_Di0    out  DW     to RAM Di0
//  ram_Do0    in   DW     from RAM Do0
// BEHAVIOUR
//  - Reset (RST=1 at edge): rvalid0/1=0, last-grant pointer=1 (req0 wins first tie), state=IDLE or INIT.
//    While RST=1: gnt0/1=0, ram_EN0=0, ram_WE0=0.
//  - States: INIT (sweep, macro only), IDLE (arbitrate). No other states.
//  - IDLE, grant rules (same cycle as req, combinational):
//    only req0 -> gnt0; only req1 -> gnt1; both -> grant requester != last-grant pointer; none -> no grant.
//    Pointer updates to the granted index on each grant edge; unchanged when idle.
//  - At most one gnt high per cycle. A held req with no gnt must hold its command stable (requester rule).
//  - On grant: ram_EN0=1, ram_WE0/A0/Di0 = winner's we/addr/wdata; otherwise ram_EN0=0, ram_WE0=0.
//  - Read (we=0) granted in cycle t -> rvalidn=1 in cycle t+1 only, rdatan=ram_Do0 (passthrough).
//    Write (we!=0): no rvalid; RAM updated at the grant edge. Partial WE writes only enabled bytes.
//  - Back-to-back: a new grant in cycle t+1 is allowed while rvalid from cycle t is high; full throughput
//    1 op/cycle. Alternating grants under continuous contention (0,1,0,1...).
//  - Read-after-write same address on consecutive cycles returns the new data.
//  - rdatan not driven from the other requester's read: rdatan = ram_Do0 but only qualified by rvalidn.
//  - Reset mid-operation: pending rvalid cleared; in-flight grant cycle aborted (EN forced 0 during RST).
// CONFIGURATION
//  DFFRAM_ARB_INIT_EN defined: after RST deasserts, state=INIT; sweep counter 0..2**AW-1, one word/cycle,
//    ram_EN0=1, ram_WE0=all ones, ram_Di0=INIT_VALUE; busy=1, gnt0/1=0 throughout; after last address
//    (2**AW cycles, 512 by default) -> IDLE, busy=0 next cycle. RST during INIT restarts sweep at address 0.
//  DFFRAM_ARB_INIT_EN undefined: no INIT state or counter; reset -> IDLE; busy tied 0; RAM contents undefined.
// TESTING
//  1. Only req0, we0=4'hF, addr0=9'h005, wdata0=32'hDEADBEEF; then read 9'h005 -> gnt0 same cycle,
//     rvalid0=1 next cycle with rdata0=32'hDEADBEEF, rvalid1 stays 0.
//  2. Byte write we1=4'b0010, wdata1=32'h0000AA00 to word holding 32'h11223344; read -> 32'h1122AA44.
//  3. req0 and req1 held high for 6 cycles (reads) -> gnt pattern 0,1,0,1,0,1; one rvalid per cycle to
//     the matching requester; never both gnt high.
//  4. Write 9'h1FF=32'hCAFEF00D by req1, next cycle read 9'h1FF by req0 -> rdata0=32'hCAFEF00D.
//  5. Assert RST in the cycle after a read grant -> rvalid0 stays 0, ram_EN0=0 during RST, post-reset
//     first tie goes to req0.
//  6. INIT_EN build, INIT_VALUE=32'h0: busy=1 for 512 cycles, req0 ignored (gnt0=0); after busy falls,
//     reads of 9'h000 and 9'h1FF return 0; RST at sweep cycle 100 -> sweep restarts, busy 512 more cycles.

Source files
------------

// File: rtl/dffram_arbiter2.sv
// dffram_arbiter2: two-requester round-robin arbiter and sequencer for one
// single-port DFFRAM macro with byte write enables.
// The winner's command is muxed onto the RAM port in the cycle it is granted.
// Read data comes back one cycle later, straight from the macro's Do0 output.
// Optional build macro DFFRAM_ARB_INIT_EN adds a power-up sweep. After reset,
// the sweep writes INIT_VALUE to every word, one word per cycle, and holds
// off all grants until it has finished.
module dffram_arbiter2 #(
  parameter int                 AW         = 9,
  parameter int                 WSIZE      = 4,
  parameter logic [8*WSIZE-1:0] INIT_VALUE = '0
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [WSIZE-1:0]     we0,
  input  logic [WSIZE-1:0]     we1,
  input  logic [AW-1:0]        addr0,
  input  logic [AW-1:0]        addr1,
  input  logic [8*WSIZE-1:0]   wdata0,
  input  logic [8*WSIZE-1:0]   wdata1,
  output logic                 gnt0,
  output logic                 gnt1,
  output logic                 rvalid0,
  output logic                 rvalid1,
  output logic [8*WSIZE-1:0]   rdata0,
  output logic [8*WSIZE-1:0]   rdata1,
  output logic                 busy,
  output logic                 ram_EN0,
  output logic [WSIZE-1:0]     ram_WE0,
  output logic [AW-1:0]        ram_A0,
  output logic [8*WSIZE-1:0]   ram_Di0,
  input  logic [8*WSIZE-1:0]   ram_Do0
);

  // Index of the requester that won most recently; a tie goes to the other one.
  logic last_gnt;
  logic rvalid0_q;
  logic rvalid1_q;
  logic arb_en;

`ifdef DFFRAM_ARB_INIT_EN
  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [AW-1:0] sweep_addr;
  logic [AW-1:0] sweep_addr_next;

  // Sweep state register: reset always restarts the sweep from word 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
    end else begin
      state      <= state_next;
      sweep_addr <= sweep_addr_next;
    end
  end

  // Next-state logic: advance one word per cycle and leave INIT after the top address.
  always_comb begin
    state_next      = state;
    sweep_addr_next = sweep_addr;
    if (state == ST_INIT) begin
      sweep_addr_next = sweep_addr + AW'(1);
      if (sweep_addr == {AW{1'b1}}) begin
        state_next = ST_IDLE;
      end
    end
  end

  assign arb_en = (state == ST_IDLE);
`else
  assign arb_en = 1'b1;
`endif

  // Grant selection and RAM port mux; nothing reaches the macro while RST is high.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    busy    = 1'b0;
    ram_EN0 = 1'b0;
    ram_WE0 = '0;
    ram_A0  = addr0;
    ram_Di0 = INIT_VALUE;

    if (!RST && arb_en) begin
      if (req0 && (!req1 || last_gnt)) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end

    if (gnt0) begin
      ram_EN0 = 1'b1;
      ram_WE0 = we0;
      ram_A0  = addr0;
      ram_Di0 = wdata0;
    end else if (gnt1) begin
      ram_EN0 = 1'b1;
      ram_WE0 = we1;
      ram_A0  = addr1;
      ram_Di0 = wdata1;
    end

`ifdef DFFRAM_ARB_INIT_EN
    if (!RST && (state == ST_INIT)) begin
      busy    = 1'b1;
      ram_EN0 = 1'b1;
      ram_WE0 = '1;
      ram_A0  = sweep_addr;
      ram_Di0 = INIT_VALUE;
    end
`endif
  end

  // Round-robin pointer and one-cycle read-return flags.
  always_ff @(posedge CLK) begin
    if (RST) begin
      last_gnt  <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      rvalid0_q <= gnt0 && (we0 == '0);
      rvalid1_q <= gnt1 && (we1 == '0);
      if (gnt0) begin
        last_gnt <= 1'b0;
      end else if (gnt1) begin
        last_gnt <= 1'b1;
      end
    end
  end

  // A read return that lands on a reset cycle is dropped.
  // The macro output feeds both requesters; rvalid tells each one when the data is its own.
  assign rvalid0 = rvalid0_q && !RST;
  assign rvalid1 = rvalid1_q && !RST;
  assign rdata0  = ram_Do0;
  assign rdata1  = ram_Do0;

  // The macro has a single port, so two grants in one cycle can never be legal.
  always @(posedge CLK) begin
    assert (!(gnt0 && gnt1));
  end

endmodule

// File: tb/tb_dffram_arbiter2.sv
// tb_dffram_arbiter2: directed vector table plus randomized traffic checked
// against a simple word-array model of the RAM and a round-robin rule.
// Define DFFRAM_ARB_INIT_EN for both files to exercise the init sweep.
module tb_dffram_arbiter2;

  localparam logic Y = 1'b1;
  localparam logic N = 1'b0;

  logic        CLK = 1'b0;
  logic        RST;
  logic        req0, req1;
  logic [3:0]  we0, we1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, busy;
  logic [31:0] rdata0, rdata1;
  logic        ram_EN0;
  logic [3:0]  ram_WE0;
  logic [8:0]  ram_A0;
  logic [31:0] ram_Di0;
  logic [31:0] ram_Do0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  dffram_arbiter2 dut (
    .CLK(CLK), .RST(RST),
    .req0(req0), .req1(req1),
    .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .busy(busy),
    .ram_EN0(ram_EN0), .ram_WE0(ram_WE0), .ram_A0(ram_A0),
    .ram_Di0(ram_Di0), .ram_Do0(ram_Do0)
  );

  // DFFRAM stand-in: the first edge seeds every word with a known non-zero pattern.
  logic [31:0] ram_mem [0:511];
  logic        seeded = 1'b0;
  always @(posedge CLK) begin
    if (!seeded) begin
      for (int i = 0; i < 512; i++) ram_mem[i] <= 32'hA5A50000 | i;
      seeded <= 1'b1;
    end else if (ram_EN0) begin
      ram_Do0 <= ram_mem[ram_A0];
      for (int b = 0; b < 4; b++)
        if (ram_WE0[b]) ram_mem[ram_A0][8*b +: 8] <= ram_Di0[8*b +: 8];
    end
  end

  typedef struct {
    logic rst;
    logic r0; logic [3:0] w0; logic [8:0] a0; logic [31:0] d0;
    logic r1; logic [3:0] w1; logic [8:0] a1; logic [31:0] d1;
    logic eg0; logic eg1; logic ev0; logic ev1; logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic rst,
                              input logic r0, input logic [3:0] w0, input logic [8:0] a0, input logic [31:0] d0,
                              input logic r1, input logic [3:0] w1, input logic [8:0] a1, input logic [31:0] d1,
                              input logic eg0, input logic eg1, input logic ev0, input logic ev1,
                              input logic [31:0] erd);
    vec_t v;
    v.rst = rst;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
    return v;
  endfunction

  task automatic checkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic checkWord(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge CLK);
    #1;
    RST = v.rst;
    req0 = v.r0; we0 = v.w0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; addr1 = v.a1; wdata1 = v.d1;
    #3;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [3:0] ewe;
    ewe = v.eg0 ? v.w0 : (v.eg1 ? v.w1 : 4'h0);
    checkBit($sformatf("row%0d gnt0", idx), gnt0, v.eg0);
    checkBit($sformatf("row%0d gnt1", idx), gnt1, v.eg1);
    checkBit($sformatf("row%0d ram_EN0", idx), ram_EN0, v.eg0 | v.eg1);
    checkWord($sformatf("row%0d ram_WE0", idx), 32'(ram_WE0), 32'(ewe));
    if (v.eg0) checkWord($sformatf("row%0d ram_A0", idx), 32'(ram_A0), 32'(v.a0));
    if (v.eg1) checkWord($sformatf("row%0d ram_A0", idx), 32'(ram_A0), 32'(v.a1));
    checkBit($sformatf("row%0d rvalid0", idx), rvalid0, v.ev0);
    checkBit($sformatf("row%0d rvalid1", idx), rvalid1, v.ev1);
    if (v.ev0) checkWord($sformatf("row%0d rdata0", idx), rdata0, v.erd);
    if (v.ev1) checkWord($sformatf("row%0d rdata1", idx), rdata1, v.erd);
    checkBit($sformatf("row%0d busy", idx), busy, 1'b0);
  endtask

  vec_t idle_v;

  // Release reset and, in the sweep build, wait for the sweep to finish.
  task automatic waitInitDone();
`ifdef DFFRAM_ARB_INIT_EN
    bit done;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      applyStimulus(idle_v);
      if (!busy) done = 1'b1;
    end
    checkBit("init_done_in_time", done, 1'b1);
`endif
  endtask

  // Reference model: memory words, round-robin pointer, one pending read return.
  logic [31:0] model_mem [16];
  int          ref_last;
  int          pend_who;
  logic [31:0] pend_data;

  task automatic modelCycle(input logic r0, input logic [3:0] w0, input logic [8:0] a0, input logic [31:0] d0,
                            input logic r1, input logic [3:0] w1, input logic [8:0] a1, input logic [31:0] d1,
                            output int winner);
    int w;
    logic [3:0] we;
    logic [8:0] a;
    logic [31:0] d;
    applyStimulus(mk(N, r0, w0, a0, d0, r1, w1, a1, d1, N, N, N, N, 32'h0));
    w = -1;
    if (r0 && r1) w = 1 - ref_last;
    else if (r0) w = 0;
    else if (r1) w = 1;
    checkBit("rnd gnt0", gnt0, w == 0);
    checkBit("rnd gnt1", gnt1, w == 1);
    checkBit("rnd ram_EN0", ram_EN0, w >= 0);
    checkBit("rnd rvalid0", rvalid0, pend_who == 0);
    checkBit("rnd rvalid1", rvalid1, pend_who == 1);
    if (pend_who == 0) checkWord("rnd rdata0", rdata0, pend_data);
    if (pend_who == 1) checkWord("rnd rdata1", rdata1, pend_data);
    pend_who = -1;
    if (w >= 0) begin
      ref_last = w;
      we = (w == 0) ? w0 : w1;
      a  = (w == 0) ? a0 : a1;
      d  = (w == 0) ? d0 : d1;
      if (we == 4'h0) begin
        pend_who  = w;
        pend_data = model_mem[a[3:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (we[b]) model_mem[a[3:0]][8*b +: 8] = d[8*b +: 8];
      end
    end
    winner = w;
  endtask

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int bad;
    int cnt;
    bit done;
    int win;
    logic c_r0, c_r1;
    logic [3:0] c_w0, c_w1;
    logic [8:0] c_a0, c_a1;
    logic [31:0] c_d0, c_d1;

    idle_v = mk(N, N, 4'h0, 9'h0, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0);
    RST = 1'b1;
    req0 = 1'b0; we0 = 4'h0; addr0 = 9'h0; wdata0 = 32'h0;
    req1 = 1'b0; we1 = 4'h0; addr1 = 9'h0; wdata1 = 32'h0;
    repeat (3) @(posedge CLK);

`ifdef DFFRAM_ARB_INIT_EN
    // Sweep with req0 pending the whole time; reset at sweep cycle 100 must restart it.
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(mk(N, Y, 4'h0, 9'h000, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0));
      if (!busy || gnt0 || !ram_EN0 || ram_A0 != 9'(k) || ram_WE0 != 4'hF || ram_Di0 != 32'h0) bad++;
    end
    applyStimulus(mk(Y, Y, 4'h0, 9'h000, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0));
    checkBit("sweep_rst_en", ram_EN0, 1'b0);
    checkBit("sweep_rst_gnt0", gnt0, 1'b0);
    cnt = 0;
    done = 1'b0;
    for (int n = 0; n < 600 && !done; n++) begin
      applyStimulus(mk(N, Y, 4'h0, 9'h000, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0));
      if (busy) begin
        if (ram_A0 != 9'(cnt) || gnt0 || !ram_EN0 || ram_WE0 != 4'hF || ram_Di0 != 32'h0) bad++;
        cnt++;
      end else begin
        done = 1'b1;
      end
    end
    checkBit("sweep_finished", done, 1'b1);
    checkWord("busy_cycles", 32'(cnt), 32'd512);
    checkWord("sweep_bad_cycles", 32'(bad), 32'd0);
    checkBit("first_idle_gnt0", gnt0, 1'b1);
    applyStimulus(mk(N, N, 4'h0, 9'h0, 32'h0, Y, 4'h0, 9'h1FF, 32'h0, N, N, N, N, 32'h0));
    checkBit("init_rd1ff_gnt1", gnt1, 1'b1);
    checkBit("init_rd000_rvalid0", rvalid0, 1'b1);
    checkWord("init_rd000_rdata0", rdata0, 32'h0);
    applyStimulus(idle_v);
    checkBit("init_rd1ff_rvalid1", rvalid1, 1'b1);
    checkWord("init_rd1ff_rdata1", rdata1, 32'h0);
`else
    // Without the sweep a request is served in the first cycle after reset.
    applyStimulus(mk(N, Y, 4'h0, 9'h003, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0));
    checkBit("post_reset_busy", busy, 1'b0);
    checkBit("post_reset_gnt0", gnt0, 1'b1);
    applyStimulus(idle_v);
    checkBit("post_reset_rvalid0", rvalid0, 1'b1);
    checkWord("post_reset_rdata0", rdata0, 32'hA5A50003);
`endif

    //                rst  r0 we0   a0      d0             r1 we1   a1      d1             g0 g1 v0 v1 rdata
    tbl.push_back(mk(Y, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, N, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'hF, 9'h005, 32'hDEADBEEF, N, 4'h0, 9'h000, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        N, 4'h0, 9'h000, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        N, 4'h0, 9'h000, 32'h0,        N, N, Y, N, 32'hDEADBEEF));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        Y, 4'hF, 9'h010, 32'h11223344, N, Y, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        Y, 4'h2, 9'h010, 32'h0000AA00, N, Y, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, Y, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        N, 4'h0, 9'h000, 32'h0,        N, N, N, Y, 32'h1122AA44));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, Y, Y, N, 32'hDEADBEEF));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        Y, N, N, Y, 32'h1122AA44));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, Y, Y, N, 32'hDEADBEEF));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        Y, N, N, Y, 32'h1122AA44));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, Y, Y, N, 32'hDEADBEEF));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        N, 4'h0, 9'h000, 32'h0,        N, N, N, Y, 32'h1122AA44));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        Y, 4'hF, 9'h1FF, 32'hCAFEF00D, N, Y, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'h0, 9'h1FF, 32'h0,        N, 4'h0, 9'h000, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        N, 4'h0, 9'h000, 32'h0,        N, N, Y, N, 32'hCAFEF00D));
    tbl.push_back(mk(N, Y, 4'h0, 9'h005, 32'h0,        N, 4'h0, 9'h000, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(Y, Y, 4'h0, 9'h005, 32'h0,        Y, 4'h0, 9'h010, 32'h0,        N, N, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'hF, 9'h020, 32'h00000055, Y, 4'hF, 9'h021, 32'h00000066, Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        Y, 4'hF, 9'h021, 32'h00000066, N, Y, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'h0, 9'h020, 32'h0,        Y, 4'h0, 9'h021, 32'h0,        Y, N, N, N, 32'h0));
    tbl.push_back(mk(N, Y, 4'h0, 9'h020, 32'h0,        Y, 4'h0, 9'h021, 32'h0,        N, Y, Y, N, 32'h00000055));
    tbl.push_back(mk(N, N, 4'h0, 9'h000, 32'h0,        N, 4'h0, 9'h000, 32'h0,        N, N, N, Y, 32'h00000066));

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i], i);
      if (tbl[i].rst) waitInitDone();
    end

    // Randomized traffic on words 0..15 after a fresh reset and a prefill.
    applyStimulus(mk(Y, N, 4'h0, 9'h0, 32'h0, N, 4'h0, 9'h0, 32'h0, N, N, N, N, 32'h0));
    waitInitDone();
    ref_last = 1;
    pend_who = -1;
    pend_data = 32'h0;
    for (int a = 0; a < 16; a++)
      modelCycle(Y, 4'hF, 9'(a), $urandom, N, 4'h0, 9'h0, 32'h0, win);
    win = -1;
    c_r0 = 1'b0; c_w0 = 4'h0; c_a0 = 9'h0; c_d0 = 32'h0;
    c_r1 = 1'b0; c_w1 = 4'h0; c_a1 = 9'h0; c_d1 = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!(c_r0 && win != 0)) begin
        c_r0 = ($urandom_range(0, 9) < 6);
        c_w0 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        c_a0 = 9'($urandom_range(0, 15));
        c_d0 = $urandom;
      end
      if (!(c_r1 && win != 1)) begin
        c_r1 = ($urandom_range(0, 9) < 6);
        c_w1 = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
        c_a1 = 9'($urandom_range(0, 15));
        c_d1 = $urandom;
      end
      modelCycle(c_r0, c_w0, c_a0, c_d0, c_r1, c_w1, c_a1, c_d1, win);
    end
    modelCycle(N, 4'h0, 9'h0, 32'h0, N, 4'h0, 9'h0, 32'h0, win);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
